// File: rtl/imem_loader.sv
// Host-side instruction memory loader: streams host words into imem and holds the core in reset while loading.
// Optional checksum accumulator is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              write_to_imem,
  output logic [ADDR_W-1:0] addr_imem_host,
  output logic [DATA_W-1:0] imem_data,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, RELEASE} state_t;

  localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W:0]   remaining;
  logic              hold;
  logic              handshake;
  logic              count_ok;
  logic              accept_start;

  assign handshake    = host_valid && host_ready;
  assign count_ok     = (word_count != '0) && (word_count <= MAX_COUNT);
  assign accept_start = (state == IDLE) && start && count_ok;

  // hold is registered, but rst is ORed in so the core is held from the very first reset cycle
  assign core_rst = rst | hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      host_ready     <= 1'b0;
      write_to_imem  <= 1'b0;
      addr_imem_host <= '0;
      imem_data      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      hold           <= 1'b0;
      addr_cnt       <= '0;
      remaining      <= '0;
    end else begin
      write_to_imem <= handshake;
      done          <= 1'b0;
      err           <= 1'b0;
      if (handshake) begin
        addr_imem_host <= addr_cnt;
        imem_data      <= host_data;
        addr_cnt       <= addr_cnt + ADDR_W'(1);
        remaining      <= remaining - (ADDR_W+1)'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            if (count_ok) begin
              addr_cnt   <= base_addr;
              remaining  <= word_count;
              state      <= LOAD;
              host_ready <= 1'b1;
              busy       <= 1'b1;
              hold       <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (handshake && remaining == (ADDR_W+1)'(1)) begin
            state      <= DRAIN;
            host_ready <= 1'b0;
          end
        end
        DRAIN: begin
          state <= RELEASE;
          hold  <= 1'b0;
          done  <= 1'b1;
        end
        RELEASE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  always_ff @(posedge clk) begin
    if (rst)
      csum <= '0;
    else if (accept_start)
      csum <= '0;
    else if (handshake)
      csum <= csum ^ host_data;
  end

  assign checksum = csum;
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/imem_loader.md
# imem_loader

Host-side program loader sitting directly upstream of the instruction-fetch stage's host-injection port. It accepts 32-bit instruction words from the host register interface over a valid/ready handshake and sequences them into instruction memory as registered `write_to_imem` / `addr_imem_host` / `imem_data` writes. While a load is in progress it holds the core in reset, then releases it with a one-cycle `done` pulse.

## Interface
Parameters:
- `ADDR_W`, 9: imem address width.
- `DATA_W`, 32: instruction word width.
- `DEPTH`, 512: imem depth in words; must equal 2^ADDR_W.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first imem address to write; latched on an accepted `start`.
- `word_count`  in  ADDR_W+1  number of words to load; valid range 1..DEPTH; latched on `start`.
- `host_valid`  in  1  host word available.
- `host_data`  in  DATA_W  host instruction word.
- `host_ready`  out  1  loader accepts a word this cycle.
- `write_to_imem`  out  1  imem write strobe, registered.
- `addr_imem_host`  out  ADDR_W  imem write address, registered.
- `imem_data`  out  DATA_W  imem write data, registered.
- `core_rst`  out  1  holds the fetch/pipeline in reset.
- `busy`  out  1  a load is in progress.
- `done`  out  1  one-cycle pulse when a load completes.
- `err`  out  1  one-cycle pulse when `start` is rejected.
- `checksum`  out  DATA_W  running XOR of loaded words; see Configuration.

## Operation
- States: IDLE, LOAD, DRAIN, RELEASE.
- IDLE:
  - `start` with `word_count` in 1..DEPTH: latch `base_addr` into the address counter and `word_count` into the remaining counter, clear `checksum`, go to LOAD.
  - `start` with `word_count` of 0 or greater than DEPTH: pulse `err`, stay in IDLE.
- LOAD:
  - `host_ready` = 1.
  - A handshake (`host_valid` && `host_ready`) registers the write, increments the address, and decrements remaining.
  - The address counter wraps modulo DEPTH (511 + 1 = 0).
  - The handshake that brings remaining to 0 moves the FSM to DRAIN.
  - Without `host_valid`, the loader waits indefinitely and `write_to_imem` is 0 the next cycle.
- DRAIN: `host_ready` = 0; the last registered write is on the outputs; go to RELEASE.
- RELEASE: `write_to_imem` = 0, `core_rst` = 0, `done` = 1 for this cycle; go to IDLE.
- `core_rst` = 1 in LOAD and DRAIN; 0 in IDLE and RELEASE. The host must not assert `start` while the core is executing code it relies on.
- `busy` = 1 in LOAD, DRAIN and RELEASE.
- `start` outside IDLE is ignored: no `err`, no state change.
- `host_valid` outside LOAD is ignored; the word is not consumed.

## Timing
- Reset values:
  - state IDLE
  - `host_ready`, `write_to_imem`, `busy`, `done`, `err` = 0
  - `addr_imem_host`, `imem_data`, `checksum` = 0
  - `core_rst` = 1 during reset and 0 after reset in IDLE.
- Write path:
  - Handshake at edge N → `write_to_imem` = 1 with the matching address/data during cycle N+1.
  - imem captures the word at edge N+2.
  - The write strobe is driven low in every cycle that had no handshake at the prior edge.
- Latency: accepted `start` → `host_ready` high the next cycle. Final handshake → `done` two cycles later.
- Back-to-back handshakes give one write per cycle, with contiguous addresses.
- Reset mid-load aborts immediately: state IDLE, no further writes, partially written imem contents stay as written.
- A single-word load (`word_count` = 1) traverses LOAD → DRAIN → RELEASE in exactly three cycles after the handshake-free first LOAD cycle is excluded.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined:
  - `checksum` is a register XOR-accumulating each accepted `host_data`.
  - It is cleared on accepted `start` and holds after `done` until the next accepted `start`.
- Undefined: `checksum` is tied to 0 and no accumulator logic is generated.

## Test plan
- Reset, then `start`, `base_addr` = 0, `word_count` = 4, words 0xA0000001..0xA0000004 sent back-to-back → writes at addresses 0..3 on consecutive cycles; `done` pulses 2 cycles after the 4th handshake; `checksum` = 0x00000004 with the macro defined, 0 without.
- `base_addr` = 510, `word_count` = 3 → writes to addresses 510, 511, 0.
- `word_count` = 0, then `word_count` = 513 → `err` pulses each time; state stays IDLE; `host_ready` stays 0.
- Host deasserts `host_valid` for 5 cycles between words 2 and 3 of a 4-word load → no writes during the gap; addresses stay contiguous; `core_rst` stays 1 throughout.
- `rst` asserted after 2 of 6 words → next cycle: IDLE, `write_to_imem` = 0, `busy` = 0; a subsequent `start` loads correctly from `base_addr`.
- `start` pulsed during LOAD with different `base_addr`/`word_count` → ignored; the original load completes unchanged.
